// File: rtl/operand_stage.sv
// -----------------------------------------------------------------------------
// operand_stage
//
// Operand-fetch / writeback stage in front of a combinational function unit.
// Holds a small register file (R0 hard-wired to zero), accepts one micro-op
// per cycle over a valid/ready handshake, registers the operands and control
// onto the function unit inputs, and writes the function unit result back
// when the downstream side accepts the op. A commit in the same cycle as an
// issue is forwarded to the issuing op's operand reads.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   InValid / InReady   upstream handshake for a new micro-op
//   DA, AA, BA          destination, A-operand and B-operand register addresses
//   MB, ConstantIn      B-operand select (1: immediate) and the immediate value
//   FS, SHIn, RW        function select, shift amount, register write enable
//   A, B                registered operands to the function unit
//   FunctionSelect, SH  registered FS and SHIn
//   OutValid/OutReady   downstream handshake; OutValid && OutReady is a commit
//   Result, flags       function unit result and Overflow/CarryOut/Negative/Zero
//   Status              flags latched on commit as {V,C,N,Z}
// -----------------------------------------------------------------------------
module operand_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int SHIFTER_WIDTH = 5,
   parameter int ADDR_WIDTH    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [ADDR_WIDTH-1:0]    DA,
   input  logic [ADDR_WIDTH-1:0]    AA,
   input  logic [ADDR_WIDTH-1:0]    BA,
   input  logic                     MB,
   input  logic [DATA_WIDTH-1:0]    ConstantIn,
   input  logic [3:0]               FS,
   input  logic [SHIFTER_WIDTH-1:0] SHIn,
   input  logic                     RW,
   output logic [DATA_WIDTH-1:0]    A,
   output logic [DATA_WIDTH-1:0]    B,
   output logic [3:0]               FunctionSelect,
   output logic [SHIFTER_WIDTH-1:0] SH,
   output logic                     OutValid,
   input  logic                     OutReady,
   input  logic [DATA_WIDTH-1:0]    Result,
   input  logic                     Overflow,
   input  logic                     CarryOut,
   input  logic                     Negative,
   input  logic                     Zero,
   output logic [3:0]               Status
);

   localparam int NumRegs = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]    regFile_q [NumRegs];

   logic [DATA_WIDTH-1:0]    a_q, a_d;
   logic [DATA_WIDTH-1:0]    b_q, b_d;
   logic [3:0]               fs_q, fs_d;
   logic [SHIFTER_WIDTH-1:0] sh_q, sh_d;
   logic [ADDR_WIDTH-1:0]    da_q, da_d;
   logic                     rw_q, rw_d;
   logic                     outValid_q, outValid_d;
   logic [3:0]               status_q, status_d;

   logic                     commit;
   logic                     issue;
   logic                     wbEn;
   logic [DATA_WIDTH-1:0]    fwdA;
   logic [DATA_WIDTH-1:0]    fwdB;

   // Handshake decode. The stage is one op deep, so it can accept a new op
   // whenever it is empty or its current op leaves this cycle.
   always_comb begin
      commit  = outValid_q && OutReady;
      InReady = !outValid_q || OutReady;
      issue   = InValid && InReady;
      wbEn    = commit && rw_q && (da_q != '0);
   end

   // Operand read with writeback bypass: a result being written on this edge
   // is handed straight to an op issuing on the same edge. wbEn already
   // excludes R0, so a write aimed at R0 is never forwarded.
   always_comb begin
      fwdA = '0;
      fwdB = '0;
      if (wbEn && (da_q == AA)) begin
         fwdA = Result;
      end else if (AA != '0) begin
         fwdA = regFile_q[AA];
      end
      if (wbEn && (da_q == BA)) begin
         fwdB = Result;
      end else if (BA != '0) begin
         fwdB = regFile_q[BA];
      end
   end

   // Next-state for the pipeline register. Everything holds by default, which
   // is what keeps the op frozen while downstream stalls. Issue overwrites the
   // op; a commit without a following issue empties the stage.
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      fs_d       = fs_q;
      sh_d       = sh_q;
      da_d       = da_q;
      rw_d       = rw_q;
      outValid_d = outValid_q;
      status_d   = status_q;
      if (commit) begin
         status_d   = {Overflow, CarryOut, Negative, Zero};
         outValid_d = 1'b0;
      end
      if (issue) begin
         a_d        = fwdA;
         b_d        = MB ? ConstantIn : fwdB;
         fs_d       = FS;
         sh_d       = SHIn;
         da_d       = DA;
         rw_d       = RW;
         outValid_d = 1'b1;
      end
   end

   // Pipeline register. Reset discards any pending op without writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         fs_q       <= '0;
         sh_q       <= '0;
         da_q       <= '0;
         rw_q       <= 1'b0;
         outValid_q <= 1'b0;
         status_q   <= '0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         fs_q       <= fs_d;
         sh_q       <= sh_d;
         da_q       <= da_d;
         rw_q       <= rw_d;
         outValid_q <= outValid_d;
         status_q   <= status_d;
      end
   end

   // Register file writeback. R0 is never written, so it stays at its reset
   // value, and reads of address 0 are forced to zero above regardless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NumRegs; i++) begin
            regFile_q[i] <= '0;
         end
      end else if (wbEn) begin
         regFile_q[da_q] <= Result;
      end
   end

   assign A              = a_q;
   assign B              = b_q;
   assign FunctionSelect = fs_q;
   assign SH             = sh_q;
   assign OutValid       = outValid_q;
   assign Status         = status_q;

endmodule

// File: tb/tb_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_stage
//
// Bench for operand_stage. A small combinational function unit closes the loop
// from A/B/FunctionSelect/SH back to Result and the flags. The reference model
// keeps the architectural register file, the single pending op and the status
// flags, and advances them one accepted edge at a time.
// -----------------------------------------------------------------------------
module tb_operand_stage;

   logic        clk;
   logic        rst;
   logic        InValid;
   logic        InReady;
   logic [2:0]  DA, AA, BA;
   logic        MB;
   logic [31:0] ConstantIn;
   logic [3:0]  FS;
   logic [4:0]  SHIn;
   logic        RW;
   logic [31:0] A, B;
   logic [3:0]  FunctionSelect;
   logic [4:0]  SH;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] Result;
   logic        Overflow, CarryOut, Negative, Zero;
   logic [3:0]  Status;

   int compared;
   int mismatched;

   // Reference model state
   logic [31:0] mReg [8];
   logic        mPv;
   logic [31:0] mA, mB;
   logic [3:0]  mFs;
   logic [4:0]  mSh;
   logic [2:0]  mDa;
   logic        mRw;
   logic [3:0]  mStatus;
   logic        obsInReady;
   logic        expInReady;

   operand_stage #(
      .DATA_WIDTH   (32),
      .SHIFTER_WIDTH(5),
      .ADDR_WIDTH   (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .InValid       (InValid),
      .InReady       (InReady),
      .DA            (DA),
      .AA            (AA),
      .BA            (BA),
      .MB            (MB),
      .ConstantIn    (ConstantIn),
      .FS            (FS),
      .SHIn          (SHIn),
      .RW            (RW),
      .A             (A),
      .B             (B),
      .FunctionSelect(FunctionSelect),
      .SH            (SH),
      .OutValid      (OutValid),
      .OutReady      (OutReady),
      .Result        (Result),
      .Overflow      (Overflow),
      .CarryOut      (CarryOut),
      .Negative      (Negative),
      .Zero          (Zero),
      .Status        (Status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Function unit behaviour, returned as {V,C,N,Z,result}
   function automatic logic [35:0] fuModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] fs, input logic [4:0] sh);
      logic [32:0] s;
      logic [31:0] r;
      logic        v;
      logic        c;
      v = 1'b0;
      c = 1'b0;
      s = '0;
      case (fs)
         4'b0010: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'b0101: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0];
            c = s[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'b1000: r = a & b;
         4'b1001: r = a | b;
         4'b1010: r = a ^ b;
         4'b1100: r = b;
         4'b1101: r = a << sh;
         4'b1110: r = a >> sh;
         default: r = a;
      endcase
      return {v, c, r[31], (r == 32'd0), r};
   endfunction

   logic [35:0] fuOut;
   always_comb fuOut = fuModel(A, B, FunctionSelect, SH);
   assign Result   = fuOut[31:0];
   assign Zero     = fuOut[32];
   assign Negative = fuOut[33];
   assign CarryOut = fuOut[34];
   assign Overflow = fuOut[35];

   task automatic modelReset();
      for (int i = 0; i < 8; i++) mReg[i] = '0;
      mPv = 1'b0; mA = '0; mB = '0; mFs = '0; mSh = '0; mDa = '0; mRw = 1'b0;
      mStatus = '0;
   endtask

   // Drives one cycle of inputs from a negedge, advances the model over the
   // following rising edge, and returns at the next negedge with outputs settled.
   task automatic applyStimulus(input logic iv, input logic [2:0] da, input logic [2:0] aa,
                                input logic [2:0] ba, input logic mb, input logic [31:0] k,
                                input logic [3:0] fs, input logic [4:0] sh, input logic rw,
                                input logic ordy);
      logic [35:0] f;
      logic        doCommit;
      InValid = iv; DA = da; AA = aa; BA = ba; MB = mb; ConstantIn = k;
      FS = fs; SHIn = sh; RW = rw; OutReady = ordy;
      #1;
      obsInReady = InReady;
      expInReady = !mPv || ordy;
      doCommit   = mPv && ordy;
      if (doCommit) begin
         f = fuModel(mA, mB, mFs, mSh);
         mStatus = f[35:32];
         if (mRw && mDa != 3'd0) mReg[mDa] = f[31:0];
      end
      // Operand reads see the register file as it stands after this edge's write
      if (iv && expInReady) begin
         mA  = (aa == 3'd0) ? 32'd0 : mReg[aa];
         mB  = mb ? k : ((ba == 3'd0) ? 32'd0 : mReg[ba]);
         mFs = fs; mSh = sh; mDa = da; mRw = rw;
         mPv = 1'b1;
      end else if (doCommit) begin
         mPv = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      InValid = 0; DA = 0; AA = 0; BA = 0; MB = 0; ConstantIn = 0; FS = 0; SHIn = 0;
      RW = 0; OutReady = 0; rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      modelReset();
      compared++;
      if (A !== 32'd0 || B !== 32'd0 || OutValid !== 1'b0 || Status !== 4'd0 ||
          FunctionSelect !== 4'd0 || SH !== 5'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got A=%h B=%h OV=%b St=%h FS=%h SH=%h, expected all zero",
                  A, B, OutValid, Status, FunctionSelect, SH);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      compared++;
      if (InReady !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_inready: got %b expected 1", InReady);
      end
      @(negedge clk);
   endtask

   task automatic test_immediate_load();
      applyStimulus(1, 3'd1, 3'd0, 3'd0, 1, 32'd5, 4'b1100, 5'd0, 1, 1);
      compared++;
      if (B !== 32'd5 || OutValid !== 1'b1 || B !== mB) begin
         mismatched++;
         $display("[TB] FAIL imm_issue: got B=%h OV=%b expected B=%h OV=1", B, OutValid, mB);
      end
      applyStimulus(0, 3'd0, 3'd0, 3'd0, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      compared++;
      if (Status !== 4'b0000 || OutValid !== 1'b0 || Status !== mStatus) begin
         mismatched++;
         $display("[TB] FAIL imm_commit: got St=%h OV=%b expected St=%h OV=0", Status, OutValid, mStatus);
      end
      applyStimulus(1, 3'd0, 3'd1, 3'd1, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      compared++;
      if (A !== 32'd5 || A !== mA || B !== mB) begin
         mismatched++;
         $display("[TB] FAIL imm_readback: got A=%h B=%h expected A=%h B=%h", A, B, mA, mB);
      end
   endtask

   task automatic test_forwarding();
      applyStimulus(1, 3'd2, 3'd1, 3'd1, 0, 32'd0, 4'b0010, 5'd0, 1, 1);
      compared++;
      if (A !== 32'd5 || B !== 32'd5) begin
         mismatched++;
         $display("[TB] FAIL fwd_op1: got A=%h B=%h expected 5/5", A, B);
      end
      applyStimulus(1, 3'd3, 3'd2, 3'd1, 0, 32'd0, 4'b0010, 5'd0, 1, 1);
      compared++;
      if (obsInReady !== 1'b1 || A !== 32'd10 || A !== mA || B !== 32'd5) begin
         mismatched++;
         $display("[TB] FAIL fwd_op2: got InReady=%b A=%h B=%h expected 1/%h/5", obsInReady, A, B, mA);
      end
      applyStimulus(0, 3'd0, 3'd0, 3'd0, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      applyStimulus(1, 3'd0, 3'd3, 3'd2, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      compared++;
      if (A !== 32'd15 || B !== 32'd10 || A !== mA) begin
         mismatched++;
         $display("[TB] FAIL fwd_result: got R3=%h R2=%h expected 15/10", A, B);
      end
   endtask

   task automatic test_stall();
      logic [31:0] holdA, holdB;
      logic [3:0]  holdSt;
      applyStimulus(1, 3'd4, 3'd1, 3'd0, 1, 32'h0000_1234, 4'b1100, 5'd3, 1, 1);
      holdA = A; holdB = B; holdSt = Status;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 3'd5, 3'd2, 3'd3, 1, $urandom, 4'b1010, 5'd7, 1, 0);
         compared++;
         if (obsInReady !== 1'b0 || expInReady !== 1'b0 || OutValid !== 1'b1 || A !== holdA ||
             B !== holdB || Status !== holdSt || SH !== 5'd3 || B !== 32'h0000_1234) begin
            mismatched++;
            $display("[TB] FAIL stall_hold: got InReady=%b OV=%b A=%h B=%h St=%h SH=%h expected 0/1/%h/%h/%h/3",
                     obsInReady, OutValid, A, B, Status, SH, holdA, holdB, holdSt);
         end
      end
      applyStimulus(0, 3'd0, 3'd0, 3'd0, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      compared++;
      if (OutValid !== 1'b0 || Status !== mStatus) begin
         mismatched++;
         $display("[TB] FAIL stall_commit: got OV=%b St=%h expected 0/%h", OutValid, Status, mStatus);
      end
      applyStimulus(1, 3'd0, 3'd4, 3'd5, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      compared++;
      if (A !== 32'h0000_1234 || B !== mB || B !== 32'd0) begin
         mismatched++;
         $display("[TB] FAIL stall_write: got R4=%h R5=%h expected 1234/0", A, B);
      end
   endtask

   task automatic test_r0_protect();
      applyStimulus(1, 3'd0, 3'd0, 3'd0, 1, 32'hFFFF_FFFF, 4'b1100, 5'd0, 1, 1);
      applyStimulus(1, 3'd0, 3'd0, 3'd0, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      compared++;
      if (A !== 32'd0 || B !== 32'd0 || Status !== 4'b0010 || Status !== mStatus) begin
         mismatched++;
         $display("[TB] FAIL r0_protect: got A=%h B=%h St=%h expected 0/0/2", A, B, Status);
      end
   endtask

   task automatic test_flags();
      applyStimulus(1, 3'd5, 3'd0, 3'd0, 1, 32'h7FFF_FFFF, 4'b1100, 5'd0, 1, 1);
      applyStimulus(1, 3'd6, 3'd5, 3'd0, 1, 32'd1, 4'b0010, 5'd0, 0, 1);
      compared++;
      if (A !== 32'h7FFF_FFFF || B !== 32'd1) begin
         mismatched++;
         $display("[TB] FAIL flags_issue: got A=%h B=%h expected 7fffffff/1", A, B);
      end
      applyStimulus(0, 3'd0, 3'd0, 3'd0, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      compared++;
      if (Status !== 4'b1010 || Status !== mStatus) begin
         mismatched++;
         $display("[TB] FAIL flags_status: got %b expected 1010", Status);
      end
      applyStimulus(1, 3'd0, 3'd6, 3'd5, 0, 32'd0, 4'b0000, 5'd0, 0, 1);
      compared++;
      if (A !== 32'd0 || B !== 32'h7FFF_FFFF || A !== mA) begin
         mismatched++;
         $display("[TB] FAIL flags_noreg: got R6=%h R5=%h expected 0/7fffffff", A, B);
      end
   endtask

   task automatic test_random();
      logic [3:0] fsList [8];
      fsList[0] = 4'b0010; fsList[1] = 4'b0101; fsList[2] = 4'b1000; fsList[3] = 4'b1001;
      fsList[4] = 4'b1010; fsList[5] = 4'b1100; fsList[6] = 4'b1101; fsList[7] = 4'b1110;
      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom,
                       fsList[$urandom_range(0, 7)], 5'($urandom_range(0, 31)),
                       $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
         compared++;
         if (obsInReady !== expInReady || OutValid !== mPv || A !== mA || B !== mB ||
             FunctionSelect !== mFs || SH !== mSh || Status !== mStatus) begin
            mismatched++;
            $display("[TB] FAIL random_%0d: got Rdy=%b OV=%b A=%h B=%h FS=%h SH=%h St=%h expected %b/%b/%h/%h/%h/%h/%h",
                     i, obsInReady, OutValid, A, B, FunctionSelect, SH, Status,
                     expInReady, mPv, mA, mB, mFs, mSh, mStatus);
         end
      end
   endtask

   task automatic test_reset_mid();
      applyStimulus(1, 3'd7, 3'd0, 3'd0, 1, 32'hDEAD_BEEF, 4'b1100, 5'd1, 1, 0);
      applyStimulus(1, 3'd1, 3'd0, 3'd0, 1, 32'h1111_1111, 4'b0101, 5'd2, 1, 0);
      InValid = 0; OutReady = 1;
      rst = 1'b1;
      #1;
      modelReset();
      compared++;
      if (OutValid !== 1'b0 || Status !== 4'd0 || A !== 32'd0 || B !== 32'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid: got OV=%b St=%h A=%h B=%h expected all zero", OutValid, Status, A, B);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int r = 1; r < 8; r++) begin
         applyStimulus(1, 3'd0, 3'(r), 3'(r), 0, 32'd0, 4'b0000, 5'd0, 0, 1);
         compared++;
         if (A !== 32'd0 || B !== 32'd0 || A !== mA) begin
            mismatched++;
            $display("[TB] FAIL reset_reg_R%0d: got %h/%h expected 0", r, A, B);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_immediate_load();
      test_forwarding();
      test_stall();
      test_r0_protect();
      test_flags();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
